// File: rtl/mem_arb_pkg.sv
// Shared types and default sizes for the memory-port arbiter.
//   - default lane counts / lane widths for the config and data address bundles
//   - arbiter FSM state encoding
//   - default-width single-requester bundle types
package mem_arb_pkg;

   localparam int CFG_LANES_DEF = 8;
   localparam int CFG_AW_DEF    = 17;
   localparam int MEM_LANES_DEF = 8;
   localparam int MEM_AW_DEF    = 16;

   typedef enum logic {
      IDLE    = 1'b0,
      GRANTED = 1'b1
   } arb_state_e;

   typedef logic [CFG_LANES_DEF*CFG_AW_DEF-1:0] cfg_addr_t;
   typedef logic [MEM_LANES_DEF*MEM_AW_DEF-1:0] mem_addr_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational winner selection for the arbiter.
//   req   in  N      candidate request vector
//   ptr   in  IW     index of the last grantee (round-robin start point)
//   rr_en in  1      1 = round-robin from ptr+1, 0 = highest set index wins
//   found out 1      any candidate present
//   idx   out IW     chosen index (0 when nothing found)
module rr_picker #(
   parameter int N  = 2,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   input  logic          rr_en,
   output logic          found,
   output logic [IW-1:0] idx
);

   logic upper_hit;

   always_comb begin
      found     = |req;
      idx       = '0;
      upper_hit = 1'b0;
      if (rr_en) begin
         // Lowest set bit strictly above ptr; descending scan so the last hit is the lowest.
         for (int i = N - 1; i >= 0; i--) begin
            if (req[i] && (i > int'(ptr))) begin
               idx       = IW'(i);
               upper_hit = 1'b1;
            end
         end
         // Nothing above ptr: wrap to the lowest set bit overall.
         if (!upper_hit) begin
            for (int i = N - 1; i >= 0; i--) begin
               if (req[i]) idx = IW'(i);
            end
         end
      end else begin
         for (int i = 0; i < N; i++) begin
            if (req[i]) idx = IW'(i);
         end
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// N-way arbiter for the shared config-memory / data-memory address ports.
//   clk              in   clock
//   rst              in   synchronous active-high reset
//   request          in   per-requester request level
//   done             in   release pulse, honoured only on the granted index
//   caddress         in   packed config address bundles, requester i at slice i
//   maddress         in   packed data address bundles, requester i at slice i
//   grant            out  registered one-hot grant, zero when idle
//   grant_valid      out  any grant active
//   grant_id         out  index of the current grantee
//   config_address   out  config bundle of the grantee, zero when idle
//   data_mem_address out  data bundle of the grantee, zero when idle
//   timeout_pulse    out  one-cycle pulse after a forced release
//
// state   | meaning
// IDLE    | no grant outstanding, waiting for any request
// GRANTED | grant_id owns the ports until drop, done or hold timeout
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int NUM_REQ   = 2,
   parameter int CFG_LANES = CFG_LANES_DEF,
   parameter int CFG_AW    = CFG_AW_DEF,
   parameter int MEM_LANES = MEM_LANES_DEF,
   parameter int MEM_AW    = MEM_AW_DEF,
   parameter int RR_EN     = 1,
   parameter int MAX_HOLD  = 16
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic [NUM_REQ-1:0]                    request,
   input  logic [NUM_REQ-1:0]                    done,
   input  logic [NUM_REQ*CFG_LANES*CFG_AW-1:0]   caddress,
   input  logic [NUM_REQ*MEM_LANES*MEM_AW-1:0]   maddress,
   output logic [NUM_REQ-1:0]                    grant,
   output logic                                  grant_valid,
   output logic [$clog2(NUM_REQ)-1:0]            grant_id,
   output logic [CFG_LANES*CFG_AW-1:0]           config_address,
   output logic [MEM_LANES*MEM_AW-1:0]           data_mem_address,
   output logic                                  timeout_pulse
);

   localparam int IW = $clog2(NUM_REQ);
   localparam int CW = CFG_LANES * CFG_AW;
   localparam int MW = MEM_LANES * MEM_AW;
   // With no timeout the counter is still kept one bit wide so the design elaborates.
   localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
   localparam logic [HW-1:0] HOLD_LIMIT = HW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
   localparam logic [HW-1:0] HOLD_SAT   = {HW{1'b1}};

   arb_state_e        state_q, state_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic [IW-1:0]      gid_q, gid_d;
   logic [IW-1:0]      ptr_q, ptr_d;
   logic [HW-1:0]      hold_cnt_q, hold_cnt_d;
   logic               to_q, to_d;

   logic [NUM_REQ-1:0] pick_req;
   logic               pick_found;
   logic [IW-1:0]      pick_idx;
   logic               rel_drop, rel_done, rel_timeout;

   // While granted only the other requesters compete, so a release hands over at once.
   assign pick_req = (state_q == GRANTED) ? (request & ~grant_q) : request;

   rr_picker #(
      .N  (NUM_REQ),
      .IW (IW)
   ) u_picker (
      .req   (pick_req),
      .ptr   (ptr_q),
      .rr_en (RR_EN != 0),
      .found (pick_found),
      .idx   (pick_idx)
   );

   assign rel_drop    = !request[gid_q];
   assign rel_done    = done[gid_q];
   // A timeout is only a forced release when the grantee would otherwise have kept the grant.
   assign rel_timeout = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LIMIT) && !rel_drop && !rel_done;

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      gid_d      = gid_q;
      ptr_d      = ptr_q;
      hold_cnt_d = hold_cnt_q;
      to_d       = 1'b0;
      case (state_q)
         IDLE: begin
            if (pick_found) begin
               state_d          = GRANTED;
               grant_d          = '0;
               grant_d[pick_idx] = 1'b1;
               gid_d            = pick_idx;
               ptr_d            = pick_idx;
               hold_cnt_d       = '0;
            end
         end
         GRANTED: begin
            if (rel_drop || rel_done || rel_timeout) begin
               to_d = rel_timeout;
               if (pick_found) begin
                  grant_d           = '0;
                  grant_d[pick_idx] = 1'b1;
                  gid_d             = pick_idx;
                  ptr_d             = pick_idx;
                  hold_cnt_d        = '0;
               end else if (rel_timeout) begin
                  hold_cnt_d = '0;
               end else begin
                  state_d = IDLE;
                  grant_d = '0;
               end
            end else if (hold_cnt_q != HOLD_SAT) begin
               hold_cnt_d = hold_cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         grant_q    <= '0;
         gid_q      <= '0;
         ptr_q      <= IW'(NUM_REQ - 1);
         hold_cnt_q <= '0;
         to_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         gid_q      <= gid_d;
         ptr_q      <= ptr_d;
         hold_cnt_q <= hold_cnt_d;
         to_q       <= to_d;
      end
   end

   assign grant            = grant_q;
   assign grant_valid      = |grant_q;
   assign grant_id         = gid_q;
   assign timeout_pulse    = to_q;
   assign config_address   = grant_valid ? caddress[int'(gid_q)*CW +: CW] : '0;
   assign data_mem_address = grant_valid ? maddress[int'(gid_q)*MW +: MW] : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a 4-way round-robin instance with a 4-cycle hold
// limit (dut_a, checked against a behavioural model) and a 2-way fixed-priority
// instance without timeout (dut_b, directed checks).
module tb_mem_port_arbiter;

   localparam int NA  = 4;
   localparam int NB  = 2;
   localparam int SW  = 16;   // 2 lanes x 8 bits per requester slice
   localparam int HLD = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic [NA-1:0]    req_a = '0, done_a = '0;
   logic [NA*SW-1:0] cadd_a = '0, madd_a = '0;
   logic [NA-1:0]    grant_a;
   logic             valid_a, to_a;
   logic [1:0]       id_a;
   logic [SW-1:0]    cfg_a, mem_a;

   logic [NB-1:0]    req_b = '0, done_b = '0;
   logic [NB*SW-1:0] cadd_b = '0, madd_b = '0;
   logic [NB-1:0]    grant_b;
   logic             valid_b, to_b;
   logic [0:0]       id_b;
   logic [SW-1:0]    cfg_b, mem_b;

   int checks = 0;
   int failures = 0;

   // behavioural model of dut_a
   bit m_valid;
   int m_id, m_held, m_ptr;
   bit m_to;

   always #5 clk = ~clk;

   mem_port_arbiter #(
      .NUM_REQ(NA), .CFG_LANES(2), .CFG_AW(8), .MEM_LANES(2), .MEM_AW(8),
      .RR_EN(1), .MAX_HOLD(HLD)
   ) dut_a (
      .clk(clk), .rst(rst), .request(req_a), .done(done_a),
      .caddress(cadd_a), .maddress(madd_a), .grant(grant_a), .grant_valid(valid_a),
      .grant_id(id_a), .config_address(cfg_a), .data_mem_address(mem_a),
      .timeout_pulse(to_a)
   );

   mem_port_arbiter #(
      .NUM_REQ(NB), .CFG_LANES(2), .CFG_AW(8), .MEM_LANES(2), .MEM_AW(8),
      .RR_EN(0), .MAX_HOLD(0)
   ) dut_b (
      .clk(clk), .rst(rst), .request(req_b), .done(done_b),
      .caddress(cadd_b), .maddress(madd_b), .grant(grant_b), .grant_valid(valid_b),
      .grant_id(id_b), .config_address(cfg_b), .data_mem_address(mem_b),
      .timeout_pulse(to_b)
   );

   // Round-robin choice: first requester after the last grantee, wrapping.
   function automatic int rr_pick(input logic [NA-1:0] r, input int last);
      for (int k = 1; k <= NA; k++) begin
         int i;
         i = (last + k) % NA;
         if (r[i]) return i;
      end
      return -1;
   endfunction

   task automatic model_step();
      logic [NA-1:0] others;
      bit dropped, fin, tmo;
      int w;
      if (rst) begin
         m_valid = 0; m_id = 0; m_held = 0; m_ptr = NA - 1; m_to = 0;
         return;
      end
      m_to = 0;
      if (!m_valid) begin
         w = rr_pick(req_a, m_ptr);
         if (w >= 0) begin
            m_valid = 1; m_id = w; m_held = 1; m_ptr = w;
         end
      end else begin
         dropped = !req_a[m_id];
         fin     = done_a[m_id];
         tmo     = (m_held == HLD) && !dropped && !fin;
         if (dropped || fin || tmo) begin
            m_to   = tmo;
            others = req_a;
            others[m_id] = 1'b0;
            w = rr_pick(others, m_ptr);
            if (w >= 0) begin
               m_id = w; m_held = 1; m_ptr = w;
            end else if (tmo) begin
               m_held = 1;
            end else begin
               m_valid = 0;
            end
         end else begin
            m_held++;
         end
      end
   endtask

   // One clock: the model sees the same inputs as the DUTs at the edge; outputs are read 1 time unit later.
   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; req_a = 4'b1111;
      tick(); tick();
      checks++; if (grant_a !== 4'b0000) begin failures++; $display("FAIL reset_grant_a got=%b exp=0000", grant_a); end
      checks++; if (valid_a !== 1'b0) begin failures++; $display("FAIL reset_valid_a got=%b exp=0", valid_a); end
      checks++; if (id_a !== 2'd0) begin failures++; $display("FAIL reset_id_a got=%0d exp=0", id_a); end
      checks++; if (to_a !== 1'b0) begin failures++; $display("FAIL reset_to_a got=%b exp=0", to_a); end
      checks++; if (cfg_a !== '0 || mem_a !== '0) begin failures++; $display("FAIL reset_addr_a got=%h/%h exp=0", cfg_a, mem_a); end
      checks++; if (grant_b !== 2'b00) begin failures++; $display("FAIL reset_grant_b got=%b exp=00", grant_b); end
      req_a = '0;
      rst = 1'b0;
      tick();
   endtask

   task automatic test_fixed_priority();
      cadd_b = {16'hC1C1, 16'hC0C0};
      madd_b = {16'hD1D1, 16'hD0D0};
      req_b = 2'b11;
      tick();
      checks++; if (grant_b !== 2'b10) begin failures++; $display("FAIL fp_grant got=%b exp=10", grant_b); end
      checks++; if (id_b !== 1'b1) begin failures++; $display("FAIL fp_id got=%0d exp=1", id_b); end
      checks++; if (cfg_b !== 16'hC1C1) begin failures++; $display("FAIL fp_cfg got=%h exp=c1c1", cfg_b); end
      checks++; if (mem_b !== 16'hD1D1) begin failures++; $display("FAIL fp_mem got=%h exp=d1d1", mem_b); end
      done_b = 2'b01;
      tick();
      done_b = 2'b00;
      checks++; if (grant_b !== 2'b10) begin failures++; $display("FAIL fp_done_other got=%b exp=10", grant_b); end
      tick(); tick();
      checks++; if (grant_b !== 2'b10 || to_b !== 1'b0) begin failures++; $display("FAIL fp_no_timeout got=%b/%b exp=10/0", grant_b, to_b); end
      req_b = 2'b01;
      tick();
      checks++; if (grant_b !== 2'b01 || cfg_b !== 16'hC0C0) begin failures++; $display("FAIL fp_handover got=%b/%h exp=01/c0c0", grant_b, cfg_b); end
      req_b = 2'b00;
      tick();
      checks++; if (grant_b !== 2'b00 || cfg_b !== '0) begin failures++; $display("FAIL fp_idle got=%b/%h exp=00/0", grant_b, cfg_b); end
      done_b = 2'b11;
      tick();
      done_b = 2'b00;
      checks++; if (grant_b !== 2'b00) begin failures++; $display("FAIL fp_done_idle got=%b exp=00", grant_b); end
   endtask

   task automatic test_rr_sequence();
      int exp_seq[5] = '{0, 1, 2, 3, 0};
      do_reset();
      req_a = 4'b1111;
      tick();
      checks++; if (grant_a !== 4'b0001) begin failures++; $display("FAIL rr_first got=%b exp=0001", grant_a); end
      for (int k = 1; k < 5; k++) begin
         done_a = 4'b0001 << id_a;
         tick();
         done_a = '0;
         checks++; if (id_a !== 2'(exp_seq[k]) || valid_a !== 1'b1) begin failures++; $display("FAIL rr_seq step=%0d got=%0d exp=%0d", k, id_a, exp_seq[k]); end
      end
      req_a = '0;
      tick();
   endtask

   task automatic test_timeout();
      do_reset();
      req_a = 4'b0001;
      tick();
      for (int k = 1; k <= 16; k++) begin
         if (k == 13) req_a = 4'b0011;
         tick();
         if (k < 16) begin
            checks++; if (grant_a !== 4'b0001 || to_a !== (k % 4 == 0)) begin failures++; $display("FAIL to_hold k=%0d got=%b/%b exp=0001/%0d", k, grant_a, to_a, (k % 4 == 0)); end
         end else begin
            checks++; if (grant_a !== 4'b0010 || to_a !== 1'b1) begin failures++; $display("FAIL to_move got=%b/%b exp=0010/1", grant_a, to_a); end
         end
      end
   endtask

   task automatic test_handover();
      // grant currently on requester 1 with requester 0 still requesting
      req_a = 4'b0101;
      tick();
      checks++; if (grant_a !== 4'b0100 || valid_a !== 1'b1) begin failures++; $display("FAIL ho_drop1 got=%b/%b exp=0100/1", grant_a, valid_a); end
      req_a = 4'b0001;
      tick();
      checks++; if (grant_a !== 4'b0001 || valid_a !== 1'b1) begin failures++; $display("FAIL ho_drop2 got=%b/%b exp=0001/1", grant_a, valid_a); end
   endtask

   task automatic test_reset_mid_grant();
      cadd_a = 64'h3333_2222_1111_0000;
      madd_a = 64'h7777_6666_5555_4444;
      req_a = 4'b1111;
      tick();
      checks++; if (valid_a !== 1'b1) begin failures++; $display("FAIL rmg_pre got=%b exp=1", valid_a); end
      rst = 1'b1;
      tick();
      checks++; if (grant_a !== '0 || cfg_a !== '0 || mem_a !== '0) begin failures++; $display("FAIL rmg_drop got=%b/%h/%h exp=0", grant_a, cfg_a, mem_a); end
      rst = 1'b0;
      tick();
      checks++; if (grant_a !== 4'b0001 || cfg_a !== 16'h0000 || mem_a !== 16'h4444) begin failures++; $display("FAIL rmg_regrant got=%b/%h/%h exp=0001/0000/4444", grant_a, cfg_a, mem_a); end
      req_a = '0;
      tick();
   endtask

   task automatic test_done_ignored();
      done_a = 4'b1111;
      tick();
      checks++; if (grant_a !== '0) begin failures++; $display("FAIL di_idle got=%b exp=0000", grant_a); end
      done_a = '0;
      req_a = 4'b0100;
      tick();
      done_a = 4'b1011;
      tick();
      done_a = '0;
      checks++; if (grant_a !== 4'b0100) begin failures++; $display("FAIL di_other got=%b exp=0100", grant_a); end
      req_a = '0;
      tick();
   endtask

   task automatic test_random();
      logic [NA-1:0] exp_g;
      logic [SW-1:0] exp_c, exp_m;
      for (int n = 0; n < 3000; n++) begin
         for (int i = 0; i < NA; i++) begin
            if ($urandom_range(7) == 0) req_a[i] = ~req_a[i];
            done_a[i] = ($urandom_range(9) == 0);
         end
         cadd_a = {$urandom, $urandom};
         madd_a = {$urandom, $urandom};
         rst = ($urandom_range(249) == 0);
         tick();
         exp_g = m_valid ? (4'b0001 << m_id) : 4'b0000;
         exp_c = m_valid ? cadd_a[m_id*SW +: SW] : '0;
         exp_m = m_valid ? madd_a[m_id*SW +: SW] : '0;
         checks++; if (!$onehot0(grant_a)) begin failures++; $display("FAIL rnd_onehot n=%0d got=%b exp=onehot0", n, grant_a); end
         checks++;
         if (grant_a !== exp_g || valid_a !== m_valid || to_a !== m_to || cfg_a !== exp_c || mem_a !== exp_m) begin
            failures++;
            $display("FAIL rnd_model n=%0d got g=%b v=%b to=%b c=%h m=%h exp g=%b v=%b to=%b c=%h m=%h",
                     n, grant_a, valid_a, to_a, cfg_a, mem_a, exp_g, m_valid, m_to, exp_c, exp_m);
         end
      end
      rst = 1'b0;
      req_a = '0;
      done_a = '0;
      tick();
   endtask

   initial begin
      test_reset();
      test_fixed_priority();
      test_rr_sequence();
      test_timeout();
      test_handover();
      test_reset_mid_grant();
      test_done_ignored();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
